stage_sequencer: RTL

Central game-flow controller for the rhythm game.
- Owns the top-level game state: start screen, four difficulty stages, failure, clear.
- Schedules enemy spawns beat by beat from the slow game tick, and emits the lane/position code consumed by the enemy sprite and hit-judge logic.
- Replaces the ad-hoc top-level FSM and fixed script. All logic runs on clk; tick is a one-cycle enable.

---
 rtl/stage_sequencer_pkg.sv | 42 ++++
 rtl/stage_sequencer_spawn_lfsr.sv | 43 ++++
 rtl/stage_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the game-flow controller: state codes and
// per-difficulty beat divisor and spawn threshold.
package stage_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_GAMESTART = 4'd0,
        ST_EASY      = 4'd1,
        ST_NORMAL    = 4'd2,
        ST_HARD      = 4'd3,
        ST_INFERNO   = 4'd4,
        ST_FAILURE   = 4'd5,
        ST_CLEAR     = 4'd6
    } state_e;

    localparam logic [3:0] POS_NONE = 4'd0;

    // Last prescaler value before a beat (divisor - 1): 4, 3, 2, 1 ticks per beat.
    function automatic logic [1:0] presc_max(input state_e s);
        case (s)
            ST_EASY:   return 2'd3;
            ST_NORMAL: return 2'd2;
            ST_HARD:   return 2'd1;
            default:   return 2'd0;
        endcase
    endfunction

    // A beat spawns an enemy when lfsr[7:4] is below this value.
    function automatic logic [3:0] spawn_threshold(input state_e s);
        case (s)
            ST_EASY:    return 4'd4;
            ST_NORMAL:  return 4'd7;
            ST_HARD:    return 4'd10;
            ST_INFERNO: return 4'd13;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic is_play(input state_e s);
        return (s == ST_EASY) || (s == ST_NORMAL) || (s == ST_HARD) || (s == ST_INFERNO);
    endfunction

endpackage

// File: rtl/stage_sequencer_spawn_lfsr.sv
// 8-bit spawn LFSR. Decodes the value it is about to step to, so the
// caller can register pos/spawn in the same cycle the LFSR advances.
module spawn_lfsr
    import stage_sequencer_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [3:0] threshold_i,
    output logic [3:0] pos_o,
    output logic       hit_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_step;
    logic [7:0] lfsr_d;

    // Shift left with feedback from taps 7, 5, 4, 3; decode the stepped value.
    always_comb begin
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_d    = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = lfsr_step;
        end
        hit_o = (lfsr_step[7:4] < threshold_i);
        pos_o = hit_o ? ({2'b00, lfsr_step[1:0]} + 4'd1) : POS_NONE;
    end

    // LFSR register; reset and stage entry both restart from SEED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Top-level game-flow controller: game state FSM, beat prescaler,
// beat counter, clear-hold timer and registered enemy position output.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned BEATS      = 128,
    parameter int unsigned LEAD_IN    = 4,
    parameter int unsigned CLEAR_HOLD = 64,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       level_valid,
    input  logic [2:0] level_sel,
    input  logic       fail,
    input  logic       return_req,
    output logic [3:0] state,
    output logic [3:0] pos,
    output logic       spawn,
    output logic [7:0] beat_idx,
    output logic       gameend,
    output logic       playing
);

    localparam int unsigned HOLD_W   = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
    localparam logic [7:0]  BEATS_C  = 8'(BEATS);
    localparam logic [7:0]  LEAD_C   = 8'(LEAD_IN);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CLEAR_HOLD - 1);

    state_e            state_q, state_d;
    logic [1:0]        presc_q, presc_d;
    logic [7:0]        beat_q, beat_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        pos_q, pos_d;
    logic              spawn_q, spawn_d;
    logic              gameend_q, gameend_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [3:0]        dec_pos;
    logic              dec_hit;

    spawn_lfsr #(.SEED(SEED)) u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (lfsr_load),
        .step_i      (lfsr_step),
        .threshold_i (spawn_threshold(state_q)),
        .pos_o       (dec_pos),
        .hit_o       (dec_hit)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_GAMESTART;
            presc_q   <= '0;
            beat_q    <= '0;
            hold_q    <= '0;
            pos_q     <= POS_NONE;
            spawn_q   <= 1'b0;
            gameend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q   <= state_d;
            presc_q   <= presc_d;
            beat_q    <= beat_d;
            hold_q    <= hold_d;
            pos_q     <= pos_d;
            spawn_q   <= spawn_d;
            gameend_q <= gameend_d;
        end
    end

    // Next-state: stage selection, beat scheduling, fail/clear/return transitions.
    always_comb begin
        // NOTE: every target gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        presc_d   = presc_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        pos_d     = pos_q;
        spawn_d   = 1'b0;
        gameend_d = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_GAMESTART: begin
                pos_d = POS_NONE;
                if (level_valid && (level_sel >= 3'd1) && (level_sel <= 3'd4)) begin
                    state_d   = state_e'({1'b0, level_sel});
                    lfsr_load = 1'b1;
                    presc_d   = '0;
                    beat_d    = '0;
                end
            end
            ST_EASY, ST_NORMAL, ST_HARD, ST_INFERNO: begin
                if (fail) begin
                    // Failure pre-empts any beat or clear on the same cycle.
                    state_d = ST_FAILURE;
                    pos_d   = POS_NONE;
                end else if (tick) begin
                    if (presc_q == presc_max(state_q)) begin
                        presc_d = '0;
                        if (beat_q < BEATS_C) begin
                            lfsr_step = 1'b1;
                            beat_d    = beat_q + 8'd1;
                            if (beat_q < LEAD_C) begin
                                pos_d = POS_NONE;
                            end else begin
                                pos_d   = dec_pos;
                                spawn_d = dec_hit;
                            end
                        end else begin
                            state_d   = ST_CLEAR;
                            pos_d     = POS_NONE;
                            gameend_d = 1'b1;
                            hold_d    = '0;
                        end
                    end else begin
                        presc_d = presc_q + 2'd1;
                    end
                end
            end
            ST_FAILURE: begin
                pos_d = POS_NONE;
                if (return_req) begin
                    state_d = ST_GAMESTART;
                end
            end
            ST_CLEAR: begin
                pos_d = POS_NONE;
                if (return_req) begin
                    state_d = ST_GAMESTART;
                end else if (tick) begin
                    if (hold_q == HOLD_MAX) begin
                        state_d = ST_GAMESTART;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                // Unused encodings recover to the start screen.
                state_d = ST_GAMESTART;
                pos_d   = POS_NONE;
            end
        endcase
    end

    // Outputs: registered values plus the play-state flag.
    always_comb begin
        state    = state_q;
        pos      = pos_q;
        spawn    = spawn_q;
        beat_idx = beat_q;
        gameend  = gameend_q;
        playing  = is_play(state_q);
    end

endmodule
